// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. It takes the execute-stage address and store
// data and runs one request/acknowledge transaction on the data-memory bus.
// Loads return an aligned, sign- or zero-extended word. The pipeline is
// stalled while the access is outstanding. A watchdog aborts the access with
// bus_err when no acknowledge arrives within WAIT_LIMIT bus cycles.
module load_store_unit #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int              CNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_read_data;
    logic             r_bus_err;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [3:0]       r_bus_be;
    logic [2:0]       r_funct3;
    logic [1:0]       r_offset;
    logic [CNT_W-1:0] r_cnt;

    logic             w_request;
    logic             w_is_byte;
    logic             w_is_half;
    logic             w_aligned;
    logic [3:0]       w_be;
    logic [31:0]      w_lane_data;

    logic             w_start;
    logic             w_fault;
    logic             w_ack;
    logic             w_timeout;
    logic             w_stall;
    logic             w_misaligned;

    logic             w_ld_signed;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [31:0]      w_ld_value;

    // Decode the incoming request: access size, alignment, byte lanes and the
    // store data replicated onto every lane the size can occupy.
    always_comb begin
        w_request = mem_read | mem_write;
        w_is_byte = (funct3[1:0] == 2'b00);
        w_is_half = (funct3[1:0] == 2'b01);
        if (w_is_byte) begin
            w_aligned   = 1'b1;
            w_be        = 4'b0001 << addr[1:0];
            w_lane_data = {4{wdata[7:0]}};
        end else if (w_is_half) begin
            w_aligned   = ~addr[0];
            w_be        = addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{wdata[15:0]}};
        end else begin
            w_aligned   = (addr[1:0] == 2'b00);
            w_be        = 4'b1111;
            w_lane_data = wdata;
        end
    end

    // Pick the addressed lane of the returned bus word and extend it to 32 bits.
    always_comb begin
        w_ld_signed = ~r_funct3[2];
        case (r_offset)
            2'd0:    w_ld_byte = bus_rdata[7:0];
            2'd1:    w_ld_byte = bus_rdata[15:8];
            2'd2:    w_ld_byte = bus_rdata[23:16];
            default: w_ld_byte = bus_rdata[31:24];
        endcase
        w_ld_half = r_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_ld_value = {{24{w_ld_signed & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_value = {{16{w_ld_signed & w_ld_half[15]}}, w_ld_half};
            default: w_ld_value = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the combinational stall/misaligned outputs and the
    // one-cycle event strobes that drive the datapath registers.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a
        // value unassigned and no latch is inferred.
        w_next       = r_state;
        w_stall      = 1'b0;
        w_misaligned = 1'b0;
        w_start      = 1'b0;
        w_fault      = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    if (w_aligned) begin
                        w_stall = 1'b1;
                        w_start = 1'b1;
                        w_next  = S_BUS;
                    end else begin
                        w_misaligned = 1'b1;
                        w_fault      = 1'b1;
                    end
                end
            end
            S_BUS: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    w_ack  = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bus request fields, wait counter, error pulse and the load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= '0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_cnt       <= '0;
        end else begin
            r_bus_err <= w_timeout;

            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_write;
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_wdata <= w_lane_data;
                r_bus_be    <= w_be;
                r_funct3    <= funct3;
                r_offset    <= addr[1:0];
                r_cnt       <= '0;
            end

            if (r_state == S_BUS) begin
                if (w_ack || w_timeout) begin
                    r_bus_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // A fault or an aborted access yields zero; a completed store leaves
            // the previous load result in place.
            if (w_fault || w_timeout) begin
                r_read_data <= '0;
            end else if (w_ack && !r_bus_we) begin
                r_read_data <= w_ld_value;
            end
        end
    end

    assign read_data  = r_read_data;
    assign stall      = w_stall;
    assign misaligned = w_misaligned;
    assign bus_err    = r_bus_err;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_be     = r_bus_be;

endmodule
